// File: rtl/sample_tx_scheduler.sv
// Sample FIFO with decimation feeding a start/done serial transmit stage.
// Define SCHED_TIMEOUT_EN to add a WAIT-state watchdog that aborts stalled transfers.
module sample_tx_scheduler #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DECIM   = 1,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [15:0]              sample_data,
    input  logic                     tx_done,
    input  logic                     clr_err,
    output logic                     tx_start,
    output logic [15:0]              tx_val,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DECIM < 1 || TIMEOUT < 2) begin : g_param_check
        $error("sample_tx_scheduler: illegal DEPTH/DECIM/TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          state;
    logic [15:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DW-1:0]   dec_cnt;
    logic [DW-1:0]   dec_cnt_nxt;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop;
    logic            expire;

    assign push_req = enable && sample_valid && (dec_cnt == '0);
    assign pop      = (state == S_LOAD);
    assign full     = (level == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push at full still succeeds.
    assign wr_en    = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Decimation counter: held at zero while disabled so the first sample after enable is taken.
    always_comb begin
        dec_cnt_nxt = dec_cnt;
        if (!enable) begin
            dec_cnt_nxt = '0;
        end else if (sample_valid) begin
            dec_cnt_nxt = (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            level    <= '0;
            dec_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (wr_en && !pop) begin
                level <= level + LW'(1);
            end else if (!wr_en && pop) begin
                level <= level - LW'(1);
            end
            dec_cnt <= dec_cnt_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [TW-1:0] wait_cnt;

    // Done arriving on the expiry cycle wins over the watchdog.
    assign expire = (state == S_WAIT) && !tx_done && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wait_cnt <= '0;
            end else if (!expire) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Transfer sequencer; GAP gives the downstream stage a cycle to settle back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            tx_val   <= '0;
            busy     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (level != '0) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    tx_val   <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PW'(1);
                    tx_start <= 1'b1;
                    state    <= S_START;
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done || expire) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
